// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Level-held read/write request bus with a one-cycle ready.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // master issues requests, slave answers them
    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Grants the shared memory port to the I- or D-cache per
//               transaction; MEM_ARB_RR_EN selects round-robin tie-break.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             proc_reset,
    mem_arbiter_if.slave          i_icache,
    mem_arbiter_if.slave          i_dcache,
    mem_arbiter_if.master         o_mem,
    output logic                  arb_busy,
    output logic                  arb_grant_d,
    output logic [CNT_W-1:0]      i_grant_cnt,
    output logic [CNT_W-1:0]      d_grant_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr_d;
    logic             w_ptr_nxt;
    logic [CNT_W-1:0] r_i_cnt;
    logic [CNT_W-1:0] r_d_cnt;
    logic             w_i_req;
    logic             w_d_req;
    logic             w_i_done;
    logic             w_d_done;
    logic             w_tie_d;

    assign w_i_req = i_icache.mem_read | i_icache.mem_write;
    assign w_d_req = i_dcache.mem_read | i_dcache.mem_write;

`ifdef MEM_ARB_RR_EN
    assign w_tie_d = ~r_ptr_d;
`else
    assign w_tie_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= S_IDLE;
            r_ptr_d <= 1'b0;
            r_i_cnt <= {CNT_W{1'b0}};
            r_d_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr_d <= w_ptr_nxt;
            if (w_i_done && (r_i_cnt != c_CNT_MAX)) begin
                r_i_cnt <= r_i_cnt + c_CNT_ONE;
            end
            if (w_d_done && (r_d_cnt != c_CNT_MAX)) begin
                r_d_cnt <= r_d_cnt + c_CNT_ONE;
            end
        end
    end

    // completion takes precedence over a request dropped in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr_d;
        w_i_done    = 1'b0;
        w_d_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_state_nxt = w_tie_d ? S_GNT_D : S_GNT_I;
                end else if (w_i_req) begin
                    w_state_nxt = S_GNT_I;
                end else if (w_d_req) begin
                    w_state_nxt = S_GNT_D;
                end
            end
            S_GNT_I: begin
                if (o_mem.mem_ready) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = 1'b0;
                    w_i_done    = 1'b1;
                end else if (!w_i_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GNT_D: begin
                if (o_mem.mem_ready) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = 1'b1;
                    w_d_done    = 1'b1;
                end else if (!w_d_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem.mem_read  = 1'b0;
        o_mem.mem_write = 1'b0;
        o_mem.mem_addr  = {ADDR_W{1'b0}};
        o_mem.mem_wdata = {DATA_W{1'b0}};
        case (r_state)
            S_GNT_I: begin
                o_mem.mem_read  = i_icache.mem_read;
                o_mem.mem_write = i_icache.mem_write;
                o_mem.mem_addr  = i_icache.mem_addr;
                o_mem.mem_wdata = i_icache.mem_wdata;
            end
            S_GNT_D: begin
                o_mem.mem_read  = i_dcache.mem_read;
                o_mem.mem_write = i_dcache.mem_write;
                o_mem.mem_addr  = i_dcache.mem_addr;
                o_mem.mem_wdata = i_dcache.mem_wdata;
            end
            default: begin
            end
        endcase
    end

    assign i_icache.mem_ready = o_mem.mem_ready & (r_state == S_GNT_I);
    assign i_dcache.mem_ready = o_mem.mem_ready & (r_state == S_GNT_D);
    assign i_icache.mem_rdata = o_mem.mem_rdata;
    assign i_dcache.mem_rdata = o_mem.mem_rdata;

    assign arb_busy    = (r_state != S_IDLE);
    assign arb_grant_d = (r_state == S_GNT_D) | ((r_state == S_IDLE) & r_ptr_d);
    assign i_grant_cnt = r_i_cnt;
    assign d_grant_cnt = r_d_cnt;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 128-bit off-chip memory port between the instruction cache and the data cache. Each cache side presents the same level-held request/ready protocol the caches already drive (mem_read/mem_write held until mem_ready), and the arbiter grants one side at a time. It sits between the two cache instances and the memory model, with one registered grant decision per transaction and saturating per-side grant counters for performance reporting.

## Interface
- ADDR_W, 28: block address width (128-bit line address)
- DATA_W, 128: line width
- CNT_W, 16: width of each saturating grant counter
- clk  in  1  system clock, all state on rising edge
- proc_reset  in  1  synchronous, active-high reset
- i_mem_read / i_mem_write  in  1 each  I-cache request strobes, level-held until i_mem_ready
- i_mem_addr  in  ADDR_W  I-cache line address
- i_mem_wdata  in  DATA_W  I-cache write line
- i_mem_ready  out  1  I-cache completion, one cycle
- i_mem_rdata  out  DATA_W  read line to I-cache
- d_mem_read / d_mem_write / d_mem_addr / d_mem_wdata / d_mem_ready / d_mem_rdata: same as above for the D-cache
- mem_read / mem_write  out  1 each  request to memory
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W;  mem_ready  in  1  memory completion
- arb_busy  out  1  high while a grant is active
- arb_grant_d  out  1  1 = D-cache holds/last held the grant
- i_grant_cnt / d_grant_cnt  out  CNT_W  completed transactions per side

## Operation
- Request of a side = its read | write. Illegal read&write together is forwarded unchanged, not checked.
- States: IDLE, GNT_I, GNT_D (registered).
- IDLE: memory outputs all zero. Only I requesting -> GNT_I; only D -> GNT_D; both -> per priority rule (Configuration). None -> stay.
- GNT_x: mem_read/mem_write/mem_addr/mem_wdata are combinational copies of side x; the other side sees nothing.
- x_mem_ready = mem_ready & (state == GNT_x); the other side's ready stays 0. mem_rdata is broadcast to both i_mem_rdata and d_mem_rdata.
- mem_ready in GNT_x -> IDLE next cycle; last-grant pointer <= x; x_grant_cnt += 1, saturating at all-ones.
- Side x drops its request in GNT_x without mem_ready (abort) -> IDLE next cycle, no count, pointer unchanged.
- A cache's write-back followed by refill is two transactions; the other side may be granted between them.
- arb_grant_d = pointer while IDLE, current grant otherwise.

## Timing
- Reset values: state IDLE, pointer = I (so D wins the first tie under round-robin), counters 0; all memory-side outputs, both readys, arb_busy, arb_grant_d = 0.
- Request rising at edge t (IDLE) -> grant registered at t+1, memory request visible in cycle t+1.
- mem_ready -> x_mem_ready same cycle (zero latency); state IDLE from the next edge; a still-pending request is granted one cycle later. Each transaction has exactly one IDLE bubble.
- Requests arriving while the other side is granted wait with no time limit.
- proc_reset asserted mid-transaction: the next edge forces IDLE and zero outputs. A mem_ready in that same cycle is not counted. The memory side must accept the request being dropped.

## Configuration
- MEM_ARB_RR_EN defined: tie in IDLE goes to the side that is not the pointer (round-robin, alternates I/D under continuous contention).
- Not defined: fixed priority, D-cache always wins ties. The pointer is still kept, for arb_grant_d only.

## Test plan
- Reset, then D read addr 0x0000010 alone -> mem_read=1 with mem_addr=0x0000010 in cycle 1 after request. Memory ready after 3 cycles -> d_mem_ready pulse, d_mem_rdata = mem_rdata, d_grant_cnt=1, i_mem_ready stays 0.
- I and D request together from reset, MEM_ARB_RR_EN -> grant order D, I, D, I over 4 back-to-back transactions. Without the macro -> D, D, D while D keeps requesting, and I waits.
- D write-back (write addr 0x1234567, wdata 0xA5..A5) then refill read, with I pending -> write, then I read, then D read. mem_wdata matches per phase.
- I aborts (drops i_mem_read) two cycles into its grant -> IDLE next cycle, i_grant_cnt unchanged, memory outputs 0.
- proc_reset pulsed during GNT_D with mem_ready high -> next cycle IDLE, all outputs 0, counters 0.
- CNT_W=4, 20 I transactions -> i_grant_cnt saturates at 15.
